alu_seq: RTL and testbench

Sequential, parametrised successor to the single-cycle integer ALU in the execute stage. It keeps the existing funct/opcode selection encoding and adds registered outputs with a start/done handshake. It also adds multi-cycle signed and unsigned multiply and divide into HI/LO registers, plus mfhi/mflo reads. The execute-stage control stalls on `busy`.

---
 rtl/alu_seq.sv | 148 ++++++++++++++
 tb/tb_alu_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with start/done handshake and multi-cycle mult/div into HI/LO.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       selection,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic neg_q, neg_d, rneg_q, rneg_d, div_q, div_d, done_q, done_d, zero_q, zero_d;
  logic [WIDTH-1:0] alu, abs1, abs2, quo, rem;
  logic [WIDTH:0] sum, diff;
  logic [2*WIDTH-1:0] prod;
  logic multi, sgn;
  assign multi = selection[5:2] == 4'b0110;
  assign sgn   = !selection[0];
  assign abs1  = (sgn && op1[WIDTH-1]) ? -op1 : op1;
  assign abs2  = (sgn && op2[WIDTH-1]) ? -op2 : op2;
  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign diff  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, b_q};
  assign prod  = neg_q ? -acc_q : acc_q;
  assign quo   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  always_comb begin
    alu = op1 + op2;
    case (selection)
      6'b100010, 6'b000100: alu = op1 - op2;
      6'b100100, 6'b001100: alu = op1 & op2;
      6'b100101: alu = op1 | op2;
      6'b100111: alu = ~(op1 | op2);
      6'b100110: alu = op1 ^ op2;
      6'b101010: alu = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      6'b010000: alu = hi_q;
      6'b010010: alu = lo_q;
      default: ;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div_d    = div_q;
    result_d = result_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        if (multi) begin
          state_d = selection[1] ? DIV : MUL;
          cnt_d   = '0;
          div_d   = selection[1];
          // raw dividend is kept for the divide-by-zero HI value
          a_d     = selection[1] ? op1 : abs1;
          b_d     = abs2;
          acc_d   = {{WIDTH{1'b0}}, selection[1] ? abs1 : abs2};
          neg_d   = sgn && (op1[WIDTH-1] ^ op2[WIDTH-1]);
          rneg_d  = sgn && op1[WIDTH-1];
        end else begin
          result_d = alu;
          zero_d   = alu == '0;
          done_d   = 1'b1;
        end
      end
      MUL: begin
        acc_d   = {sum, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? FIX : MUL;
      end
      DIV: begin
        acc_d   = diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? FIX : DIV;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!div_q) {hi_d, lo_d} = prod;
        else if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
        end else begin
          lo_d = quo;
          hi_d = rem;
        end
        result_d = lo_d;
        zero_d   = lo_d == '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div_q    <= div_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end
  assign busy   = state_q != IDLE;
  assign done   = done_q;
  assign zero   = zero_q;
  assign result = result_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized scoreboard bench for alu_seq (WIDTH 32).
module tb_alu_seq;
  localparam int W = 32;
  localparam logic [5:0] OPS [16] = '{6'b100000, 6'b001000, 6'b100011, 6'b000100,
                                      6'b001100, 6'b100101, 6'b100111, 6'b100110,
                                      6'b101010, 6'b111111, 6'b011000, 6'b011001,
                                      6'b011010, 6'b011011, 6'b010000, 6'b010010};
  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [5:0] selection = '0;
  logic [W-1:0] op1 = '0, op2 = '0;
  logic busy, done, zero;
  logic [W-1:0] result, hi, lo;
  int checks = 0, failures = 0;
  exp_t scb[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;
  always #5 clk = ~clk;
  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .selection(selection),
    .op1(op1), .op2(op2), .busy(busy), .done(done), .zero(zero),
    .result(result), .hi(hi), .lo(lo)
  );
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [5:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    e.hi = m_hi;
    e.lo = m_lo;
    e.res = a + b;
    case (s)
      6'b100010, 6'b000100: e.res = a - b;
      6'b100100, 6'b001100: e.res = a & b;
      6'b100101: e.res = a | b;
      6'b100111: e.res = ~(a | b);
      6'b100110: e.res = a ^ b;
      6'b101010: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      6'b010000: e.res = m_hi;
      6'b010010: e.res = m_lo;
      6'b011000: {e.hi, e.lo} = sa * sb;
      6'b011001: {e.hi, e.lo} = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      6'b011010, 6'b011011: begin
        if (b == '0) begin
          e.lo = '1;
          e.hi = a;
        end else if (s[0]) begin
          e.lo = a / b;
          e.hi = a % b;
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
          e.lo = a;
          e.hi = '0;
        end else begin
          e.lo = W'($signed(a) / $signed(b));
          e.hi = W'($signed(a) % $signed(b));
        end
      end
      default: ;
    endcase
    if (s[5:2] == 4'b0110) e.res = e.lo;
    e.z = e.res == '0;
    return e;
  endfunction
  task automatic compare(input string tag, input exp_t e);
    check({tag, ".result"}, result, e.res);
    check({tag, ".zero"}, W'(zero), W'(e.z));
    check({tag, ".hi"}, hi, e.hi);
    check({tag, ".lo"}, lo, e.lo);
  endtask
  // caller is at a falling edge; returns at the falling edge where done is seen
  task automatic issue(input string tag, input logic [5:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n;
    logic multi;
    multi = s[5:2] == 4'b0110;
    e = model(s, a, b);
    m_hi = e.hi;
    m_lo = e.lo;
    scb.push_back(e);
    selection = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, ".busy_edge0"}, W'(busy), W'(multi));
    while (!done && n < W + 8) begin
      @(negedge clk);
      n++;
      if (n == W + 1) check({tag, ".busy_edgeW"}, W'(busy), W'(1));
    end
    check({tag, ".done_edge"}, W'(n - 1), multi ? W'(W + 1) : W'(0));
    check({tag, ".busy_at_done"}, W'(busy), W'(0));
    if (scb.size() > 0) compare(tag, scb.pop_front());
  endtask
  initial begin
    exp_t e;
    int cnt;
    #2 rst_n = 1'b0;
    #1;
    check("rst.busy", W'(busy), '0);
    check("rst.done", W'(done), '0);
    check("rst.zero", W'(zero), '0);
    check("rst.result", result, '0);
    check("rst.hi", hi, '0);
    check("rst.lo", lo, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("add", 6'b100000, 7, 5);
    check("add.const", result, 12);
    issue("sub_eq", 6'b100010, 5, 5);
    check("sub_eq.zero_const", W'(zero), W'(1));
    issue("slt", 6'b101010, '1, 1);
    check("slt.const", result, 1);
    @(negedge clk);
    check("done_width", W'(done), '0);
    issue("mult", 6'b011000, -32'sd3, 7);
    check("mult.lo_const", lo, 32'hFFFFFFEB);
    check("mult.hi_const", hi, 32'hFFFFFFFF);
    issue("mfhi_b2b", 6'b010000, 1, 2);
    check("mfhi_b2b.const", result, 32'hFFFFFFFF);
    issue("multu", 6'b011001, 32'hFFFFFFFF, 2);
    check("multu.hi_const", hi, 1);
    check("multu.lo_const", lo, 32'hFFFFFFFE);
    issue("div", 6'b011010, -32'sd7, 2);
    check("div.lo_const", lo, 32'hFFFFFFFD);
    check("div.hi_const", hi, 32'hFFFFFFFF);
    issue("divu_zero", 6'b011011, 9, 0);
    check("divu_zero.lo_const", lo, 32'hFFFFFFFF);
    check("divu_zero.hi_const", hi, 9);
    issue("div_ovf", 6'b011010, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf.lo_const", lo, 32'h80000000);
    check("div_ovf.hi_const", hi, 0);
    issue("div_neg_zero", 6'b011010, -32'sd5, 0);
    for (int i = 0; i < 16; i++)
      issue($sformatf("rand%0d", i), OPS[i], $urandom, (i % 3 == 0) ? W'($urandom_range(0, 3)) : W'($urandom));
    e = model(6'b011000, 123, -32'sd16);
    m_hi = e.hi;
    m_lo = e.lo;
    scb.push_back(e);
    selection = 6'b011000;
    op1 = 123;
    op2 = -32'sd16;
    start = 1'b1;
    @(negedge clk);
    selection = 6'b100000;
    op1 = 1;
    op2 = 2;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done) begin
        cnt++;
        if (scb.size() > 0) compare("ignored_start", scb.pop_front());
      end
    end
    check("ignored_start.done_count", W'(cnt), W'(1));
    selection = 6'b011010;
    op1 = 100;
    op2 = 7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.busy", W'(busy), '0);
    check("midrst.done", W'(done), '0);
    check("midrst.result", result, '0);
    check("midrst.hi", hi, '0);
    check("midrst.lo", lo, '0);
    m_hi = '0;
    m_lo = '0;
    scb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue("mflo_after_rst", 6'b010010, 5, 6);
    check("mflo_after_rst.const", result, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
